qam16_byte_packer: RTL and testbench
====================================

# qam16_byte_packer

Downstream neighbour of the 16-QAM demapper. Each valid demapped symbol delivers four hard bits. This block packs two consecutive symbols into one byte and tags the last byte of every frame. It buffers the bytes in a small FIFO and presents them on a valid/ready stream to the descrambler/decoder. The demapper has no backpressure, so buffer overflow is detected and reported rather than stalled.

## Interface
- DEPTH, 16: FIFO depth in bytes; power of two, ≥ 2.
- N_SYM, 48: symbols per frame; even, ≥ 2. A frame is N_SYM/2 bytes.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_frame_start  in  1  one-cycle pulse marking that the next accepted symbol is the first of a frame.
- i_valid  in  1  demapped symbol valid.
- i_bit0 / i_bit1 / i_bit2 / i_bit3  in  1 each  demapper bits: I-sign, I-mag, Q-sign, Q-mag.
- o_valid  out  1  byte available.
- o_data  out  8  packed byte.
- o_last  out  1  byte is the last of its frame.
- i_ready  in  1  consumer accepts the byte this cycle.
- o_overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- o_frag_err  out  1  sticky: a frame restart discarded a half-filled byte.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Nibble order:** nib = {i_bit0, i_bit1, i_bit2, i_bit3}, with i_bit0 as the MSB.
- **Byte layout:** the first symbol of a pair goes to byte[7:4] and the second to byte[3:0].
- **Pack FSM** has two states, HI and LO. Reset state is HI.
  - HI, with i_valid: latch nib into hold[3:0], go to LO.
  - LO, with i_valid: form byte {hold, nib}, request a push, go to HI.
  - No i_valid: hold the current state.
- **Symbol counter** sym_cnt runs 0..N_SYM-1.
  - Increments on each i_valid and wraps to 0 after N_SYM-1.
  - The pushed byte carries last = 1 when the completing symbol has sym_cnt == N_SYM-1.
- **i_frame_start:**
  - Forces sym_cnt to 0 and the FSM to HI before that cycle's i_valid is evaluated.
  - So an i_valid in the same cycle is treated as symbol 0 and latched into hold; sym_cnt becomes 1 and the FSM goes to LO.
  - If the FSM was in LO when the pulse arrives, the held nibble is discarded and o_frag_err is set.
  - A pulse while the FSM is in HI is harmless.
- **FIFO:** DEPTH × 9 bits (data + last), first-word-fall-through.
  - push = pack request; pop = o_valid & i_ready.
  - Push and pop in the same cycle are always legal. When full, the pop frees the slot, the byte is stored, and the level is unchanged.
  - Push while full without a pop: the byte is dropped, o_overflow is set, and pointers and level are unchanged. The FSM and sym_cnt advance normally, so frame alignment is kept.
  - Pop while empty cannot occur, because o_valid is 0.
  - Read and write pointers wrap modulo DEPTH; full and empty are decided from o_level.
- **Output:**
  - o_valid = (o_level != 0).
  - o_data and o_last show the FIFO head while o_valid = 1, and are forced to 0 while o_valid = 0.
  - o_data and o_last must stay stable while o_valid & !i_ready.
- **Sticky flags** (o_overflow, o_frag_err) clear only on reset.

## Timing
- **Reset (asynchronous):**
  - o_valid = 0, o_data = 0, o_last = 0, o_overflow = 0, o_frag_err = 0, o_level = 0.
  - FSM = HI, sym_cnt = 0, pointers = 0.
- Reset asserted mid-frame discards all FIFO content and any partial byte immediately.
- **Latency:** the LO-state i_valid at edge t gives o_valid = 1 after edge t (visible in cycle t+1) when the FIFO was empty. There is no added latency beyond the one register.
- **Throughput:** input is at most one symbol per clock, i.e. one byte every two clocks. With i_ready held high the FIFO never exceeds 1 entry.
- o_level updates on the same edge as the push or pop.
- Flags assert on the edge of the offending event and are visible the next cycle.

## Test plan
- **Basic pack:** reset, then i_frame_start with nibbles 0xA, 0x5, 0x3, 0xC, i_ready = 1.
  - Expect bytes 0xA5 then 0x3C, each one cycle after its second nibble, o_last = 0.
- **Frame tag:** N_SYM = 48, continuous nibbles 0..F repeating.
  - Expect 24 bytes, o_last = 1 only on byte 24 (0xEF).
  - The next frame's first byte is 0x01 with o_last = 0, without a new i_frame_start.
- **Backpressure/overflow:** i_ready = 0, DEPTH = 16, push 17 bytes.
  - Expect o_level = 16, o_overflow = 1 after the 17th byte.
  - Raise i_ready: exactly 16 bytes drain, in order.
  - The pair following the drop still maps to the correct sym_cnt/o_last.
- **Full with simultaneous push/pop:** FIFO full, i_ready = 1 on the same edge as a push.
  - o_level stays 16 and o_overflow stays 0.
- **Fragment restart:** send one nibble 0x7, then i_frame_start together with nibble 0x1, then nibble 0x2.
  - o_frag_err = 1 and the output byte is 0x12 (0x7 lost).
  - sym_cnt restart is confirmed by o_last position N_SYM/2 bytes later.
- **Reset mid-operation:** with 5 bytes queued and the FSM in LO, pulse rst_n low asynchronously (between edges).
  - All outputs go to their reset values immediately.
  - The next nibble pair after release packs from HI.

Source files
------------

// File: rtl/qam16_byte_packer_if.sv
// Symbol-in / byte-out bundle of the 16-QAM byte packer.
// The packer uses the master side. The demapper and the consumer use the slave side.
interface qam16_byte_packer_if #(
  parameter int DEPTH = 16
) ();
  logic                     i_frame_start;
  logic                     i_valid;
  logic                     i_bit0;
  logic                     i_bit1;
  logic                     i_bit2;
  logic                     i_bit3;
  logic                     i_ready;
  logic                     o_valid;
  logic [7:0]               o_data;
  logic                     o_last;
  logic                     o_overflow;
  logic                     o_frag_err;
  logic [$clog2(DEPTH):0]   o_level;

  modport master (
    input  i_frame_start, i_valid, i_bit0, i_bit1, i_bit2, i_bit3, i_ready,
    output o_valid, o_data, o_last, o_overflow, o_frag_err, o_level
  );

  modport slave (
    output i_frame_start, i_valid, i_bit0, i_bit1, i_bit2, i_bit3, i_ready,
    input  o_valid, o_data, o_last, o_overflow, o_frag_err, o_level
  );
endinterface

// File: rtl/qam16_byte_packer.sv
// Packs pairs of 16-QAM hard nibbles into bytes, tags each frame's last byte,
// and queues the bytes in a first-word-fall-through FIFO with overflow reporting.
module qam16_byte_packer #(
  parameter int DEPTH = 16,
  parameter int N_SYM = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qam16_byte_packer_if.master  bus,
  output logic                 fsm_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = (N_SYM > 2) ? $clog2(N_SYM) : 1;

  typedef enum logic {HI = 1'b0, LO = 1'b1} state_t;

  state_t          state, state_nxt, cur_state;
  logic [3:0]      hold, hold_nxt, nib;
  logic [SW-1:0]   sym_cnt, sym_nxt, cur_cnt;
  logic            push, push_last, frag_set;
  logic [7:0]      push_byte;

  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level, level_nxt;
  logic            full, pop, do_push, ovf_set;
  logic            overflow, frag_err;
  logic [8:0]      head;

  assign nib       = {bus.i_bit0, bus.i_bit1, bus.i_bit2, bus.i_bit3};
  assign fsm_state = state;

  // A frame-start pulse resets the pairing before this cycle's symbol is taken.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    sym_nxt   = sym_cnt;
    cur_state = state;
    cur_cnt   = sym_cnt;
    push      = 1'b0;
    push_byte = 8'h00;
    push_last = 1'b0;
    frag_set  = 1'b0;
    if (bus.i_frame_start) begin
      cur_state = HI;
      cur_cnt   = '0;
      state_nxt = HI;
      sym_nxt   = '0;
      frag_set  = (state == LO);
    end
    if (bus.i_valid) begin
      sym_nxt = (cur_cnt == SW'(N_SYM - 1)) ? '0 : cur_cnt + 1'b1;
      if (cur_state == HI) begin
        hold_nxt  = nib;
        state_nxt = LO;
      end else begin
        push      = 1'b1;
        push_byte = {hold, nib};
        push_last = (cur_cnt == SW'(N_SYM - 1));
        state_nxt = HI;
      end
    end
  end

  // Handshake: a byte transfers on a rising edge where o_valid and i_ready are both 1;
  // o_data/o_last hold while o_valid is 1 and i_ready is 0.
  assign full    = (level == LW'(DEPTH));
  assign pop     = bus.o_valid & bus.i_ready;
  assign do_push = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    level_nxt = level;
    case ({do_push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HI;
      hold     <= 4'h0;
      sym_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      frag_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold     <= hold_nxt;
      sym_cnt  <= sym_nxt;
      level    <= level_nxt;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)  overflow <= 1'b1;
      if (frag_set) frag_err <= 1'b1;
    end
  end

  // Storage needs no reset: level gates everything read from it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_last, push_byte};
  end

  assign head           = mem[rd_ptr];
  assign bus.o_valid    = (level != '0);
  assign bus.o_data     = bus.o_valid ? head[7:0] : 8'h00;
  assign bus.o_last     = bus.o_valid ? head[8] : 1'b0;
  assign bus.o_level    = level;
  assign bus.o_overflow = overflow;
  assign bus.o_frag_err = frag_err;
endmodule

// File: tb/tb_qam16_byte_packer.sv
// Directed bench for qam16_byte_packer: packing, frame tagging, backpressure,
// overflow, fragment restart and asynchronous reset.
module tb_qam16_byte_packer;
  localparam int DEPTH = 16;
  localparam int N_SYM = 48;

  logic clk;
  logic rst_n;
  logic fsm_state;
  int   errors = 0;
  int   checks = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  qam16_byte_packer_if #(.DEPTH(DEPTH)) bus ();

  qam16_byte_packer #(.DEPTH(DEPTH), .N_SYM(N_SYM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  // Bytes accepted by the consumer, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) got_q.push_back({bus.o_last, bus.o_data});
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_nib(input logic [3:0] n, input logic fs);
    bus.i_valid       = 1'b1;
    bus.i_frame_start = fs;
    {bus.i_bit0, bus.i_bit1, bus.i_bit2, bus.i_bit3} = n;
    @(posedge clk);
    #1;
    bus.i_valid       = 1'b0;
    bus.i_frame_start = 1'b0;
  endtask

  // Byte built from nibble values k and k+1 (mod 16) with a last tag.
  function automatic logic [8:0] pair(input int k, input logic last);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(k);
    lo = 4'(k + 1);
    return {last, hi, lo};
  endfunction

  // scenarios
  task automatic test_reset();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.o_data); end
    checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.o_last); end
    checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.o_overflow); end
    checks++; if (bus.o_frag_err !== 1'b0) begin errors++; $display("FAIL reset_frag: got %b want 0", bus.o_frag_err); end
    checks++; if (bus.o_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.o_level); end
    checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", fsm_state); end
  endtask

  task automatic test_basic_pack();
    bus.i_ready = 1'b1;
    send_nib(4'hA, 1'b1);
    send_nib(4'h5, 1'b0);
    checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'hA5 || bus.o_last !== 1'b0) begin
      errors++; $display("FAIL basic_first: got v=%b d=%h l=%b want v=1 d=a5 l=0", bus.o_valid, bus.o_data, bus.o_last); end
    send_nib(4'h3, 1'b0);
    send_nib(4'hC, 1'b0);
    checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h3C || bus.o_last !== 1'b0) begin
      errors++; $display("FAIL basic_second: got v=%b d=%h l=%b want v=1 d=3c l=0", bus.o_valid, bus.o_data, bus.o_last); end
    idle(2);
    exp_q.push_back(9'h0A5);
    exp_q.push_back(9'h03C);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL basic_byte: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_frame_tag();
    bus.i_ready = 1'b1;
    for (int k = 0; k < N_SYM + 2; k++) send_nib(4'(k), k == 0);
    idle(3);
    for (int j = 0; j < N_SYM / 2; j++) exp_q.push_back(pair(2 * j, j == N_SYM / 2 - 1));
    exp_q.push_back(9'h001);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL frame_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL frame_byte: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    apply_reset();
    bus.i_ready = 1'b0;
    for (int k = 0; k < 2 * DEPTH; k++) send_nib(4'(k), k == 0);
    checks++; if (bus.o_level !== 5'd16 || bus.o_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_full: got level=%0d ovf=%b want level=16 ovf=0", bus.o_level, bus.o_overflow); end
    checks++; if (bus.o_data !== 8'h01 || bus.o_last !== 1'b0) begin
      errors++; $display("FAIL ovf_head: got d=%h l=%b want d=01 l=0", bus.o_data, bus.o_last); end
    send_nib(4'h0, 1'b0);
    send_nib(4'h1, 1'b0);
    checks++; if (bus.o_level !== 5'd16 || bus.o_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drop: got level=%0d ovf=%b want level=16 ovf=1", bus.o_level, bus.o_overflow); end
    bus.i_ready = 1'b1;
    idle(DEPTH + 4);
    checks++; if (bus.o_level !== 5'd0) begin errors++; $display("FAIL ovf_drained: got %0d want 0", bus.o_level); end
    for (int j = 0; j < DEPTH; j++) exp_q.push_back(pair(2 * j, 1'b0));
    for (int k = 2 * DEPTH + 2; k < N_SYM; k++) send_nib(4'(k), 1'b0);
    idle(3);
    for (int j = DEPTH + 1; j < N_SYM / 2; j++) exp_q.push_back(pair(2 * j, j == N_SYM / 2 - 1));
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL ovf_byte: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    bus.i_ready = 1'b0;
    for (int k = 0; k < 2 * DEPTH; k++) send_nib(4'(k), k == 0);
    send_nib(4'h0, 1'b0);
    bus.i_ready = 1'b1;
    send_nib(4'h1, 1'b0);
    bus.i_ready = 1'b0;
    checks++; if (bus.o_level !== 5'd16 || bus.o_overflow !== 1'b0) begin
      errors++; $display("FAIL fullpp_level: got level=%0d ovf=%b want level=16 ovf=0", bus.o_level, bus.o_overflow); end
    bus.i_ready = 1'b1;
    idle(DEPTH + 4);
    for (int j = 0; j <= DEPTH; j++) exp_q.push_back(pair(2 * j, 1'b0));
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fullpp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL fullpp_byte: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_frag_restart();
    apply_reset();
    bus.i_ready = 1'b1;
    send_nib(4'h7, 1'b1);
    checks++; if (bus.o_frag_err !== 1'b0) begin errors++; $display("FAIL frag_before: got %b want 0", bus.o_frag_err); end
    send_nib(4'h1, 1'b1);
    checks++; if (bus.o_frag_err !== 1'b1) begin errors++; $display("FAIL frag_set: got %b want 1", bus.o_frag_err); end
    send_nib(4'h2, 1'b0);
    for (int k = 2; k < N_SYM; k++) send_nib(4'(k), 1'b0);
    idle(3);
    exp_q.push_back(9'h012);
    for (int j = 1; j < N_SYM / 2; j++) exp_q.push_back(pair(2 * j, j == N_SYM / 2 - 1));
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL frag_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL frag_byte: got %h want %h", g, e); end
    end
    checks++; if (bus.o_frag_err !== 1'b1) begin errors++; $display("FAIL frag_sticky: got %b want 1", bus.o_frag_err); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.i_ready = 1'b0;
    for (int k = 0; k < 11; k++) send_nib(4'(k), k == 0);
    checks++; if (bus.o_level !== 5'd5 || fsm_state !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got level=%0d state=%b want level=5 state=1", bus.o_level, fsm_state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_valid !== 1'b0 || bus.o_data !== 8'h00 || bus.o_last !== 1'b0) begin
      errors++; $display("FAIL mid_outputs: got v=%b d=%h l=%b want v=0 d=00 l=0", bus.o_valid, bus.o_data, bus.o_last); end
    checks++; if (bus.o_level !== 5'd0 || fsm_state !== 1'b0) begin
      errors++; $display("FAIL mid_state: got level=%0d state=%b want level=0 state=0", bus.o_level, fsm_state); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    bus.i_ready = 1'b1;
    send_nib(4'h9, 1'b0);
    send_nib(4'h6, 1'b0);
    idle(2);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL mid_count: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 9'h096) begin errors++; $display("FAIL mid_byte: got %h want 096", got_q[0]); end
    end
    got_q.delete();
  endtask

  // sequence and final report
  initial begin
    rst_n             = 1'b0;
    bus.i_frame_start = 1'b0;
    bus.i_valid       = 1'b0;
    bus.i_bit0        = 1'b0;
    bus.i_bit1        = 1'b0;
    bus.i_bit2        = 1'b0;
    bus.i_bit3        = 1'b0;
    bus.i_ready       = 1'b0;
    #3;
    apply_reset();
    test_reset();
    test_basic_pack();
    test_frame_tag();
    test_overflow();
    test_full_push_pop();
    test_frag_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
